// File: rtl/timer_counter_dev_if.sv
// -----------------------------------------------------------------------------
// timer_counter_dev_if
// Peripheral-bus bundle between the address-decoding bridge (master) and a
// timer_counter_dev responder (slave).
//   Addr [31:0] byte address, word accesses only       (master -> slave)
//   WE          write strobe, already store/decode-qualified (master -> slave)
//   Din  [31:0] write data                              (master -> slave)
//   Dout [31:0] read data, combinational from Addr      (slave -> master)
// -----------------------------------------------------------------------------
interface timer_counter_dev_if;
  logic [31:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;

  modport master (output Addr, output WE, output Din, input Dout);
  modport slave  (input Addr, input WE, input Din, output Dout);
endinterface

// File: rtl/timer_counter_dev.sv
// -----------------------------------------------------------------------------
// timer_counter_dev
// Memory-mapped countdown timer occupying a 16-byte window at BASE.
// Registers (offset = Addr[3:2]):
//   0 CTRL   r/w  [0] EN, [2:1] MODE, [3] IM
//   1 PRESET r/w  reload value
//   2 COUNT  r/o  current count
//   3 reserved, reads 0
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low reset
//   bus    timer_counter_dev_if.slave (Addr, WE, Din in; Dout out)
//   IRQ    registered interrupt request, IM & irq_flag
// Optional build macro TIMER_IRQ_STATUS_EN: CTRL read bit [31] returns the raw
// irq_flag (independent of IM). Without it, bit [31] reads 0.
// -----------------------------------------------------------------------------
module timer_counter_dev #(
  parameter logic [31:0] BASE = 32'h0000_7f00
) (
  input  logic                 clk,
  input  logic                 reset,
  timer_counter_dev_if.slave   bus,
  output logic                 IRQ
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_en;
  logic [1:0]  r_mode;
  logic        r_im;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_irq_flag;
  logic        r_irq;

  logic        w_hit;
  logic [1:0]  w_off;
  logic        w_wr_ctrl;
  logic        w_wr_preset;
  logic [31:0] w_ctrl_rd;
  logic [31:0] w_dout;
  logic        w_auto_reload;
  logic        w_unused;

  assign w_hit         = (bus.Addr[31:4] == BASE[31:4]);
  assign w_off         = bus.Addr[3:2];
  assign w_wr_ctrl     = bus.WE && w_hit && (w_off == 2'd0);
  assign w_wr_preset   = bus.WE && w_hit && (w_off == 2'd1);
  assign w_auto_reload = (r_mode == 2'd1);
  // Byte offset within a word is irrelevant: only word accesses exist.
  assign w_unused      = &{1'b0, bus.Addr[1:0]};

`ifdef TIMER_IRQ_STATUS_EN
  assign w_ctrl_rd = {r_irq_flag, 27'd0, r_im, r_mode, r_en};
`else
  assign w_ctrl_rd = {28'd0, r_im, r_mode, r_en};
`endif

  always_comb begin
    w_dout = 32'd0;
    if (w_hit) begin
      case (w_off)
        2'd0:    w_dout = w_ctrl_rd;
        2'd1:    w_dout = r_preset;
        2'd2:    w_dout = r_count;
        default: w_dout = 32'd0;
      endcase
    end
  end

  assign bus.Dout = w_dout;
  assign IRQ      = r_irq;

  // FSM and register file share one process so that a same-edge bus write
  // can simply be placed last and override whatever the FSM scheduled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_en       <= 1'b0;
      r_mode     <= 2'd0;
      r_im       <= 1'b0;
      r_preset   <= 32'd0;
      r_count    <= 32'd0;
      r_irq_flag <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_irq <= r_im & r_irq_flag;

      // Auto-reload turns irq_flag into a one-cycle pulse. The set in S_INT
      // below comes later in this block and therefore takes priority.
      if (r_irq_flag && w_auto_reload)
        r_irq_flag <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (r_en)
            r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_count <= r_preset;
          r_state <= S_CNT;
        end
        S_CNT: begin
          if (!r_en) begin
            r_state <= S_IDLE;
          end else if (r_count > 32'd1) begin
            r_count <= r_count - 32'd1;
          end else begin
            // Covers COUNT==1 and a PRESET of 0: saturate, never wrap.
            r_count <= 32'd0;
            r_state <= S_INT;
          end
        end
        S_INT: begin
          r_irq_flag <= 1'b1;
          r_state    <= S_IDLE;
          if (!w_auto_reload)
            r_en <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_wr_ctrl) begin
        r_en       <= bus.Din[0];
        r_mode     <= bus.Din[2:1];
        r_im       <= bus.Din[3];
        r_irq_flag <= 1'b0;
      end

      if (w_wr_preset)
        r_preset <= bus.Din;
    end
  end

endmodule

// File: tb/tb_timer_counter_dev.sv
module tb_timer_counter_dev;

  localparam logic [31:0] A_CTRL   = 32'h0000_7f00;
  localparam logic [31:0] A_PRESET = 32'h0000_7f04;
  localparam logic [31:0] A_COUNT  = 32'h0000_7f08;
  localparam logic [31:0] A_RSVD   = 32'h0000_7f0c;
  localparam logic [31:0] A_OTHER  = 32'h0000_7f14;

  logic clk;
  logic reset;
  logic IRQ;
  int   n_chk;
  int   n_pass;

  timer_counter_dev_if bus ();

  timer_counter_dev #(.BASE(32'h0000_7f00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .IRQ   (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Called in the low clock phase; reads are combinational.
  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    bus.Addr = addr;
    #1;
    data = bus.Dout;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive in low phase, commit at the next rising edge, return at the
  // following falling edge (the sample point right after the write edge).
  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus.Addr = addr;
    bus.Din  = data;
    bus.WE   = 1'b1;
    @(posedge clk);
    #1;
    bus.WE = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Reference behaviour after enabling from reset state at edge e0, sampled
  // after edge e0+k. Period T = max(P,1)+3; irq_flag sets at edge e0+T.
  task automatic run_trial(input int p, input int mode, input int im);
    int          t;
    int          c;
    logic        flag_k;
    logic        flag_prev;
    logic        en_k;
    logic [31:0] got;
    logic [31:0] exp_ctrl;
    do_reset();
    wr(A_PRESET, p);
    wr(A_CTRL, {28'd0, im[0], mode[1:0], 1'b1});
    t = imax(p, 1) + 3;
    flag_prev = 1'b0;
    for (int k = 0; k <= 2 * t + 3; k++) begin
      if (k < 2)          c = 0;
      else if (mode == 1) c = p - ((k - 2) % t);
      else                c = p - (k - 2);
      if (c < 0) c = 0;
      flag_k = (k >= t) && ((mode != 1) || (k % t == 0));
      en_k   = (mode == 1) || (k < t);
      exp_ctrl = {28'd0, im[0], mode[1:0], en_k};
`ifdef TIMER_IRQ_STATUS_EN
      exp_ctrl[31] = flag_k;
`endif
      rd(A_COUNT, got);
      chk($sformatf("count p=%0d m=%0d k=%0d", p, mode, k), got, c);
      rd(A_CTRL, got);
      chk($sformatf("ctrl p=%0d m=%0d k=%0d", p, mode, k), got, exp_ctrl);
      chk($sformatf("irq p=%0d m=%0d im=%0d k=%0d", p, mode, im, k),
          32'(IRQ), 32'(im[0] & flag_prev));
      flag_prev = flag_k;
      tick();
    end
  endtask

  initial begin
    logic [31:0] d;
    n_chk   = 0;
    n_pass  = 0;
    reset   = 1'b0;
    bus.Addr = 32'd0;
    bus.WE   = 1'b0;
    bus.Din  = 32'd0;

    // Reset values, with reset released mid-cycle
    @(negedge clk);
    do_reset();
    rd(A_CTRL, d);   chk("rst ctrl", d, 32'd0);
    rd(A_PRESET, d); chk("rst preset", d, 32'd0);
    rd(A_COUNT, d);  chk("rst count", d, 32'd0);
    chk("rst irq", 32'(IRQ), 32'd0);
    tick();
    rd(A_COUNT, d);  chk("rst count later", d, 32'd0);

    // Directed trials: one-shot, auto-reload, PRESET=0, masked expiry
    run_trial(5, 0, 1);
    wr(A_CTRL, 32'd0);
    tick();
    chk("irq dropped by ctrl write", 32'(IRQ), 32'd0);
    rd(A_CTRL, d); chk("ctrl after clear", d, 32'd0);
    run_trial(3, 1, 1);
    run_trial(0, 0, 1);
    run_trial(4, 0, 0);
    run_trial(2, 2, 1);

    // Randomized trials
    for (int i = 0; i < 6; i++)
      run_trial(int'($urandom_range(0, 12)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 1)));

    // Mid-count disable: decrement still happens on the write edge
    do_reset();
    wr(A_PRESET, 32'd10);
    wr(A_CTRL, 32'h9);
    for (int i = 0; i < 5; i++) tick();
    rd(A_COUNT, d); chk("count before disable", d, 32'd7);
    wr(A_CTRL, 32'h8);
    rd(A_COUNT, d); chk("count after disable", d, 32'd6);
    for (int i = 0; i < 4; i++) tick();
    rd(A_COUNT, d); chk("count held", d, 32'd6);
    rd(A_CTRL, d);  chk("ctrl disabled", d, 32'h8);
    chk("no irq when disabled", 32'(IRQ), 32'd0);
    wr(A_CTRL, 32'h9);
    tick();
    tick();
    rd(A_COUNT, d); chk("reload on re-enable", d, 32'd10);

    // Asynchronous reset mid-count, away from any clock edge
    tick();
    reset = 1'b0;
    #1;
    rd(A_COUNT, d); chk("async reset count", d, 32'd0);
    rd(A_CTRL, d);  chk("async reset ctrl", d, 32'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);

    // Writes to read-only, reserved and out-of-window addresses
    wr(A_PRESET, 32'h0000_1234);
    wr(A_COUNT, 32'h0000_DEAD);
    wr(A_RSVD, 32'h0000_DEAD);
    wr(A_OTHER, 32'h0000_DEAD);
    rd(A_PRESET, d);      chk("preset kept", d, 32'h0000_1234);
    rd(A_COUNT, d);       chk("count not writable", d, 32'd0);
    rd(A_RSVD, d);        chk("reserved reads 0", d, 32'd0);
    rd(A_CTRL, d);        chk("ctrl unchanged", d, 32'd0);
    rd(A_OTHER, d);       chk("miss reads 0", d, 32'd0);
    rd(32'h0000_7f07, d); chk("byte offset ignored", d, 32'h0000_1234);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
